// File: rtl/typedef_pkg.sv
// Shared types for the vector instruction queue.
// Entry layout and the NOP word shown when no head is valid.
package typedef_pkg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [1:0]  sew;
    } v_instr_entry_t;

    localparam logic [31:0] V_NOP_INSTR = 32'h0;

endpackage

// File: rtl/v_instr_queue_mem.sv
// Entry storage for v_instr_queue.
// One write port and one asynchronous read port; the array has no reset.
module v_instr_queue_mem
    import typedef_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  v_instr_entry_t wdata,
    input  logic [AW-1:0]  raddr,
    output v_instr_entry_t rdata
);

    v_instr_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/v_instr_queue.sv
// Vector instruction queue between scalar dispatch and the scheduler.
// Define V_INSTR_QUEUE_BYPASS_EN to forward a push into an empty queue.
module v_instr_queue
    import typedef_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush_i,
    input  logic          s_vld_i,
    output logic          s_rdy_o,
    input  logic [31:0]   s_instr_i,
    input  logic [31:0]   s_rs1_i,
    input  logic [31:0]   s_rs2_i,
    input  logic [1:0]    s_sew_i,
    output logic [31:0]   vector_instr_o,
    output logic [31:0]   rs1_o,
    output logic [31:0]   rs2_o,
    output logic [1:0]    sew_o,
    input  logic          vector_stall_i,
    output logic [CW-1:0] count_o,
    output logic          empty_o
);

    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [CW-1:0]  count;
    logic           full;
    logic           empty;
    logic           push;
    logic           head_vld;
    logic           pop;
    logic           wr;
    logic           rd;
    v_instr_entry_t in_entry;
    v_instr_entry_t mem_head;
    v_instr_entry_t head;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    assign s_rdy_o = !full;
    assign push    = s_vld_i && s_rdy_o;

    assign in_entry = '{instr: s_instr_i, rs1: s_rs1_i,
                        rs2: s_rs2_i, sew: s_sew_i};

`ifdef V_INSTR_QUEUE_BYPASS_EN
    logic byp;
    assign byp      = empty && s_vld_i;
    assign head_vld = !empty || byp;
    assign pop      = head_vld && !vector_stall_i;
    // A bypassed entry consumed on the spot never touches storage.
    assign wr       = push && !(byp && !vector_stall_i);
    assign rd       = pop && !empty;
    assign head     = byp ? in_entry : mem_head;
`else
    assign head_vld = !empty;
    assign pop      = head_vld && !vector_stall_i;
    assign wr       = push;
    assign rd       = pop;
    assign head     = mem_head;
`endif

    v_instr_queue_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (wr && !flush_i),
        .waddr(wptr),
        .wdata(in_entry),
        .raddr(rptr),
        .rdata(mem_head)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + 1'b1;
            end
            if (rd) begin
                rptr <= rptr + 1'b1;
            end
            if (wr && !rd) begin
                count <= count + 1'b1;
            end else if (rd && !wr) begin
                count <= count - 1'b1;
            end
        end
    end

    always_comb begin
        vector_instr_o = V_NOP_INSTR;
        rs1_o          = '0;
        rs2_o          = '0;
        sew_o          = '0;
        if (head_vld) begin
            vector_instr_o = head.instr;
            rs1_o          = head.rs1;
            rs2_o          = head.rs2;
            sew_o          = head.sew;
        end
    end

    assign count_o = count;
    assign empty_o = empty;

endmodule
